// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I funct3 codes,
// the controller state encoding and the access legality check.
package lsu_pkg;

    // Load width/sign codes
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Store width codes (share encodings with the signed loads)
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOAD_WAIT = 2'd1,
        RMW_MERGE = 2'd2,
        DONE      = 2'd3
    } state_t;

    // 1 when the access is misaligned for its width or funct3 is not a
    // legal load/store code; such requests never touch memory.
    function automatic logic access_err(input logic       i_we,
                                        input logic [2:0] i_funct3,
                                        input logic [1:0] i_off);
        logic v_err;
        v_err = 1'b1;
        if (i_we) begin
            case (i_funct3)
                F3_SB:   v_err = 1'b0;
                F3_SH:   v_err = i_off[0];
                F3_SW:   v_err = (i_off != 2'b00);
                default: v_err = 1'b1;
            endcase
        end else begin
            case (i_funct3)
                F3_LB, F3_LBU: v_err = 1'b0;
                F3_LH, F3_LHU: v_err = i_off[0];
                F3_LW:         v_err = (i_off != 2'b00);
                default:       v_err = 1'b1;
            endcase
        end
        return v_err;
    endfunction

endpackage

// File: rtl/lsu_if.sv
// Core-side request/response handshake plus the data-memory port.
//
// Handshake: a request transfers on a rising clk edge where
// req_valid & req_ready are both 1. req_ready is high only while the unit
// is idle and out of reset; req_valid may change freely while req_ready
// is low without effect. rsp_valid is a single-cycle completion pulse and
// carries no backpressure. mem_d_out returns the word addressed in the
// previous cycle (synchronous read).
interface lsu_if #(
    parameter int ADDR = 10
);
    logic            req_valid;
    logic            req_ready;
    logic            req_we;
    logic [2:0]      req_funct3;
    logic [31:0]     req_addr;
    logic [31:0]     req_wdata;
    logic            rsp_valid;
    logic [31:0]     rsp_rdata;
    logic            rsp_err;
    logic            mem_wr_en;
    logic [ADDR-1:0] mem_addr;
    logic [31:0]     mem_d_in;
    logic [31:0]     mem_d_out;

    // Load/store unit side
    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_d_out,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
               mem_wr_en, mem_addr, mem_d_in
    );

    // Core and data-memory side
    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_d_out,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
               mem_wr_en, mem_addr, mem_d_in
    );
endinterface

// File: rtl/lsu_align.sv
// Byte-lane datapath: extracts and extends load data from a memory word,
// and merges sub-word store data into a word for read-modify-write.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_off,
    input  logic [31:0] i_word,
    input  logic [15:0] i_wdata,
    output logic [31:0] o_load_data,
    output logic [31:0] o_merge_data
);
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Select the addressed byte and halfword lanes of the word
    always_comb begin
        w_byte = i_word[{i_off, 3'b000} +: 8];
        w_half = i_off[1] ? i_word[31:16] : i_word[15:0];
    end

    // Right-align and sign/zero-extend according to the load code
    always_comb begin
        o_load_data = '0;
        case (i_funct3)
            F3_LB:   o_load_data = {{24{w_byte[7]}}, w_byte};
            F3_LBU:  o_load_data = {24'h000000, w_byte};
            F3_LH:   o_load_data = {{16{w_half[15]}}, w_half};
            F3_LHU:  o_load_data = {16'h0000, w_half};
            F3_LW:   o_load_data = i_word;
            default: o_load_data = '0;
        endcase
    end

    // Replace only the addressed lanes; every other bit keeps the old word
    always_comb begin
        o_merge_data = i_word;
        if (i_funct3 == F3_SB) begin
            o_merge_data[{i_off, 3'b000} +: 8] = i_wdata[7:0];
        end else if (i_funct3 == F3_SH) begin
            o_merge_data[{i_off[1], 4'b0000} +: 16] = i_wdata;
        end
    end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit in front of a single-port, synchronous-read word
// memory. Loads take one wait cycle, word stores write on the accept
// cycle, sub-word stores do a read-modify-write. Illegal or misaligned
// requests complete with rsp_err and never write.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR = 10,
    parameter int DATA = 32
) (
    input  logic   clk,
    input  logic   rst_n,
    lsu_if.slave   bus,
    output state_t o_dbg_state
);
    state_t           r_state;
    state_t           w_next;

    // Request fields captured on accept
    logic             r_we;
    logic [2:0]       r_funct3;
    logic [1:0]       r_off;
    logic [ADDR-1:0]  r_idx;
    logic [15:0]      r_wdata;
    logic             r_err;

    logic             w_accept;
    logic             w_req_err;
    logic [ADDR-1:0]  w_req_idx;
    logic [DATA-1:0]  w_load_data;
    logic [DATA-1:0]  w_merge_data;

    logic             w_req_ready;
    logic             w_mem_wr_en;
    logic [ADDR-1:0]  w_mem_addr;
    logic [DATA-1:0]  w_mem_d_in;
    logic             w_rsp_valid;
    logic             w_rsp_err;
    logic [DATA-1:0]  w_rsp_rdata;

    // Address bits above the word index are intentionally ignored
    logic             w_unused_addr;
    assign w_unused_addr = ^bus.req_addr;

    assign w_req_idx = bus.req_addr[ADDR+1:2];
    assign w_req_err = access_err(bus.req_we, bus.req_funct3, bus.req_addr[1:0]);
    assign w_accept  = rst_n && (r_state == IDLE) && bus.req_valid;

    lsu_align u_align (
        .i_funct3     (r_funct3),
        .i_off        (r_off),
        .i_word       (bus.mem_d_out),
        .i_wdata      (r_wdata),
        .o_load_data  (w_load_data),
        .o_merge_data (w_merge_data)
    );

    // State register; reset aborts any request in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Capture the request on the accept edge for the later cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we     <= 1'b0;
            r_funct3 <= 3'b000;
            r_off    <= 2'b00;
            r_idx    <= '0;
            r_wdata  <= 16'h0000;
            r_err    <= 1'b0;
        end else if (w_accept) begin
            r_we     <= bus.req_we;
            r_funct3 <= bus.req_funct3;
            r_off    <= bus.req_addr[1:0];
            r_idx    <= w_req_idx;
            r_wdata  <= bus.req_wdata[15:0];
            r_err    <= w_req_err;
        end
    end

    // Next-state and per-state outputs
    always_comb begin
        w_next      = r_state;
        w_req_ready = 1'b0;
        w_mem_wr_en = 1'b0;
        w_mem_addr  = r_idx;
        w_mem_d_in  = '0;
        w_rsp_valid = 1'b0;
        w_rsp_err   = 1'b0;
        w_rsp_rdata = '0;
        case (r_state)
            IDLE: begin
                w_req_ready = 1'b1;
                // Address goes straight to memory so the read is issued
                // in the accept cycle itself
                w_mem_addr  = w_req_idx;
                if (bus.req_valid) begin
                    if (w_req_err) begin
                        w_next = DONE;
                    end else if (bus.req_we) begin
                        if (bus.req_funct3 == F3_SW) begin
                            w_mem_wr_en = 1'b1;
                            w_mem_d_in  = bus.req_wdata;
                            w_next      = DONE;
                        end else begin
                            w_next = RMW_MERGE;
                        end
                    end else begin
                        w_next = LOAD_WAIT;
                    end
                end
            end
            LOAD_WAIT: begin
                w_rsp_valid = 1'b1;
                w_rsp_rdata = w_load_data;
                w_next      = IDLE;
            end
            RMW_MERGE: begin
                w_mem_wr_en = 1'b1;
                w_mem_d_in  = w_merge_data;
                w_next      = DONE;
            end
            DONE: begin
                w_rsp_valid = 1'b1;
                w_rsp_err   = r_err;
                w_next      = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Outputs are forced low the moment reset is asserted
    assign bus.req_ready = rst_n & w_req_ready;
    assign bus.mem_wr_en = rst_n & w_mem_wr_en;
    assign bus.mem_addr  = rst_n ? w_mem_addr  : '0;
    assign bus.mem_d_in  = rst_n ? w_mem_d_in  : '0;
    assign bus.rsp_valid = rst_n & w_rsp_valid;
    assign bus.rsp_err   = rst_n & w_rsp_err;
    assign bus.rsp_rdata = rst_n ? w_rsp_rdata : '0;

    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: a synchronous-read memory, a
// request-level reference model with expected queues, a per-cycle
// compare process and literal checks of the key transactions.
module tb_load_store_unit;
  import lsu_pkg::*;

  localparam int ADDR = 10;
  localparam int WORDS = 1 << ADDR;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lsu_if #(.ADDR(ADDR)) bus();
  state_t dbg_state;

  load_store_unit #(.ADDR(ADDR), .DATA(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- memory environment ----------------
  function automatic logic [31:0] init_word(input int i);
    case (i)
      0: return 32'h80FF_1234;
      1: return 32'hBEEF_0000;
      2: return 32'h1122_3344;
      4: return 32'hCAFE_F00D;
      default: return 32'(i) * 32'h0101_0101;
    endcase
  endfunction

  logic [31:0] mem [0:WORDS-1];
  bit mem_loaded = 1'b0;
  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < WORDS; i++) mem[i] <= init_word(i);
      mem_loaded <= 1'b1;
    end else begin
      if (bus.mem_wr_en) mem[bus.mem_addr] <= bus.mem_d_in;
      bus.mem_d_out <= mem[bus.mem_addr];
    end
  end

  // ---------------- reference model state ----------------
  logic [31:0] ref_mem [0:WORDS-1];
  logic [32:0] exp_rsp_q[$];          // {err, rdata}
  int exp_rsp_cyc_q[$];
  logic [ADDR+31:0] exp_wr_q[$];      // {word index, data}
  int exp_wr_cyc_q[$];
  int busy_from = 1;
  int busy_until = 0;
  int acc_cyc = 0;

  // observed DUT activity for the literal checks
  logic [31:0] last_rsp_rdata = '0;
  logic last_rsp_err = 1'b0;
  int last_rsp_cyc = 0;
  int rsp_count = 0;
  logic [31:0] last_wr_data = '0;
  int last_wr_cyc = 0;
  int wr_count = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- scoreboard / compare ----------------
  always @(negedge clk) begin
    logic [32:0] e_rsp;
    logic [ADDR+31:0] e_wr;
    if (!rst_n) begin
      chk("rst_req_ready", bus.req_ready, 0);
      chk("rst_rsp_valid", bus.rsp_valid, 0);
      chk("rst_rsp_err", bus.rsp_err, 0);
      chk("rst_rsp_rdata", bus.rsp_rdata, 0);
      chk("rst_mem_wr_en", bus.mem_wr_en, 0);
      chk("rst_mem_addr", bus.mem_addr, 0);
      chk("rst_mem_d_in", bus.mem_d_in, 0);
      chk("rst_state", dbg_state, IDLE);
    end else begin
      chk("req_ready", bus.req_ready, !(cyc >= busy_from && cyc <= busy_until));
      if (exp_rsp_cyc_q.size() > 0 && exp_rsp_cyc_q[0] == cyc) begin
        e_rsp = exp_rsp_q.pop_front();
        void'(exp_rsp_cyc_q.pop_front());
        chk("rsp_valid", bus.rsp_valid, 1);
        chk("rsp_rdata", bus.rsp_rdata, e_rsp[31:0]);
        chk("rsp_err", bus.rsp_err, e_rsp[32]);
      end else begin
        chk("rsp_valid_idle", bus.rsp_valid, 0);
        chk("rsp_rdata_idle", bus.rsp_rdata, 0);
        chk("rsp_err_idle", bus.rsp_err, 0);
      end
      if (exp_wr_cyc_q.size() > 0 && exp_wr_cyc_q[0] == cyc) begin
        e_wr = exp_wr_q.pop_front();
        void'(exp_wr_cyc_q.pop_front());
        chk("mem_wr_en", bus.mem_wr_en, 1);
        chk("mem_wr_addr", bus.mem_addr, e_wr[ADDR+31:32]);
        chk("mem_wr_data", bus.mem_d_in, e_wr[31:0]);
      end else begin
        chk("mem_wr_en_idle", bus.mem_wr_en, 0);
      end
    end
    if (bus.rsp_valid === 1'b1) begin
      last_rsp_rdata = bus.rsp_rdata;
      last_rsp_err = bus.rsp_err;
      last_rsp_cyc = cyc;
      rsp_count++;
    end
    if (bus.mem_wr_en === 1'b1) begin
      last_wr_data = bus.mem_d_in;
      last_wr_cyc = cyc;
      wr_count++;
    end
  end

  // ---------------- driver ----------------
  // Called just after a rising edge while the unit is idle. Predicts the
  // outcome from the ISA rules, drives the request, keeps req_valid high
  // with junk while the unit is busy, and returns in the first idle cycle.
  task automatic do_req(input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata);
    int n, lat, sh_amt, b;
    logic [ADDR-1:0] idx;
    logic [1:0] off;
    logic legal;
    logic [31:0] word, sh, mask, nw, val;
    n = cyc;
    idx = addr[ADDR+1:2];
    off = addr[1:0];
    sh_amt = 8 * int'(off);
    if (we) legal = (f3 == 3'd0) || (f3 == 3'd1 && off[0] == 1'b0) || (f3 == 3'd2 && off == 2'd0);
    else legal = (f3 == 3'd0 || f3 == 3'd4) ||
                 ((f3 == 3'd1 || f3 == 3'd5) && off[0] == 1'b0) || (f3 == 3'd2 && off == 2'd0);
    word = ref_mem[idx];
    if (!legal) begin
      lat = 1;
      exp_rsp_q.push_back({1'b1, 32'h0}); exp_rsp_cyc_q.push_back(n + 1);
    end else if (!we) begin
      lat = 1;
      sh = word >> sh_amt;
      case (f3)
        3'd0: begin b = int'(sh[7:0]); if (b > 127) b -= 256; val = 32'(b); end
        3'd1: begin b = int'(sh[15:0]); if (b > 32767) b -= 65536; val = 32'(b); end
        3'd4: val = sh & 32'hFF;
        3'd5: val = sh & 32'hFFFF;
        default: val = word;
      endcase
      exp_rsp_q.push_back({1'b0, val}); exp_rsp_cyc_q.push_back(n + 1);
    end else if (f3 == 3'd2) begin
      lat = 1;
      exp_wr_q.push_back({idx, wdata}); exp_wr_cyc_q.push_back(n);
      ref_mem[idx] = wdata;
      exp_rsp_q.push_back({1'b0, 32'h0}); exp_rsp_cyc_q.push_back(n + 1);
    end else begin
      lat = 2;
      mask = ((f3 == 3'd0) ? 32'hFF : 32'hFFFF) << sh_amt;
      nw = (word & ~mask) | ((wdata << sh_amt) & mask);
      exp_wr_q.push_back({idx, nw}); exp_wr_cyc_q.push_back(n + 1);
      ref_mem[idx] = nw;
      exp_rsp_q.push_back({1'b0, 32'h0}); exp_rsp_cyc_q.push_back(n + 2);
    end
    acc_cyc = n;
    busy_from = n + 1;
    busy_until = n + lat;
    bus.req_valid = 1'b1;
    bus.req_we = we;
    bus.req_funct3 = f3;
    bus.req_addr = addr;
    bus.req_wdata = wdata;
    for (int i = 0; i < lat; i++) begin
      @(posedge clk); #1;
      bus.req_we = 1'($urandom_range(0, 1));
      bus.req_funct3 = 3'($urandom_range(0, 7));
      bus.req_addr = $urandom;
      bus.req_wdata = $urandom;
    end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    int wc0, rc0;
    for (int i = 0; i < WORDS; i++) ref_mem[i] = init_word(i);
    bus.req_valid = 1'b0;
    bus.req_we = 1'b0;
    bus.req_funct3 = 3'd0;
    bus.req_addr = '0;
    bus.req_wdata = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // LB sign-extends the top byte of word 0
    do_req(1'b0, 3'd0, 32'h003, 32'h0);
    chk("lb_rdata", last_rsp_rdata, 32'hFFFF_FF80);
    chk("lb_err", last_rsp_err, 0);
    chk("lb_latency", last_rsp_cyc - acc_cyc, 1);

    // LHU zero-extends the upper half of word 1
    do_req(1'b0, 3'd5, 32'h006, 32'h0);
    chk("lhu_rdata", last_rsp_rdata, 32'h0000_BEEF);

    // SB read-modify-write into lane 1 of word 2
    wc0 = wr_count;
    do_req(1'b1, 3'd0, 32'h009, 32'h0000_00AA);
    chk("sb_wr_data", last_wr_data, 32'h1122_AA44);
    chk("sb_wr_latency", last_wr_cyc - acc_cyc, 1);
    chk("sb_rsp_latency", last_rsp_cyc - acc_cyc, 2);
    chk("sb_one_write", wr_count - wc0, 1);

    // SW writes on the accept cycle, then reads back
    do_req(1'b1, 3'd2, 32'h00C, 32'hDEAD_BEEF);
    chk("sw_wr_latency", last_wr_cyc - acc_cyc, 0);
    chk("sw_rsp_latency", last_rsp_cyc - acc_cyc, 1);
    do_req(1'b0, 3'd2, 32'h00C, 32'h0);
    chk("lw_after_sw", last_rsp_rdata, 32'hDEAD_BEEF);

    // Misaligned SH: error, no write
    wc0 = wr_count;
    do_req(1'b1, 3'd1, 32'h011, 32'h0000_5555);
    chk("sh_mis_err", last_rsp_err, 1);
    chk("sh_mis_latency", last_rsp_cyc - acc_cyc, 1);
    chk("sh_mis_no_write", wr_count - wc0, 0);
    chk("sh_mis_word4", mem[4], 32'hCAFE_F00D);

    // Further widths and lanes
    do_req(1'b0, 3'd1, 32'h002, 32'h0);
    chk("lh_rdata", last_rsp_rdata, 32'hFFFF_80FF);
    do_req(1'b0, 3'd4, 32'h001, 32'h0);
    chk("lbu_rdata", last_rsp_rdata, 32'h0000_0012);
    do_req(1'b0, 3'd0, 32'h000, 32'h0);
    do_req(1'b1, 3'd1, 32'h016, 32'h1234_ABCD);
    do_req(1'b0, 3'd2, 32'h014, 32'h0);
    chk("lw_after_sh", last_rsp_rdata, 32'hABCD_0505);
    // Upper address bits are ignored
    do_req(1'b1, 3'd0, 32'hFFFF_F00A, 32'h0000_0055);
    do_req(1'b0, 3'd2, 32'h008, 32'h0);
    chk("lw_after_sb_hi", last_rsp_rdata, 32'h1155_AA44);

    // Illegal / misaligned codes
    do_req(1'b0, 3'd2, 32'h002, 32'h0);
    do_req(1'b0, 3'd3, 32'h000, 32'h0);
    chk("ld_f3_illegal_err", last_rsp_err, 1);
    do_req(1'b0, 3'd7, 32'h000, 32'h0);
    do_req(1'b1, 3'd3, 32'h000, 32'h1);
    do_req(1'b1, 3'd2, 32'h00D, 32'h1);
    do_req(1'b0, 3'd5, 32'h003, 32'h0);

    // Reset while an SB sits in RMW_MERGE aborts it
    wc0 = wr_count;
    rc0 = rsp_count;
    busy_from = cyc + 1;
    busy_until = cyc + 100;
    bus.req_valid = 1'b1;
    bus.req_we = 1'b1;
    bus.req_funct3 = 3'd0;
    bus.req_addr = 32'h01C;
    bus.req_wdata = 32'h0000_0077;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    busy_from = 1;
    busy_until = 0;
    @(negedge clk);
    chk("rst_abort_ready", bus.req_ready, 1);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_abort_no_write", wr_count - wc0, 0);
    chk("rst_abort_no_rsp", rsp_count - rc0, 0);
    chk("rst_abort_word7", mem[7], 32'h0707_0707);

    // Back to normal operation after the abort
    do_req(1'b0, 3'd2, 32'h01C, 32'h0);
    chk("lw_after_abort", last_rsp_rdata, 32'h0707_0707);

    repeat (2) @(posedge clk);
    #1;
    chk("rsp_q_drained", exp_rsp_q.size(), 0);
    chk("wr_q_drained", exp_wr_q.size(), 0);
    for (int i = 0; i < 16; i++) chk($sformatf("mem_word%0d", i), mem[i], ref_mem[i]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (checks %0d, errors %0d)", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter ADDR, default 10, meaning word-address width of the data memory (ADDR+2 <= 32).
REQ-002 SHALL have parameter DATA, default 32, meaning data width (fixed at 32).
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req_valid  input  1  core request present.
REQ-006 SHALL have port req_ready  output  1  unit can accept a request this cycle.
REQ-007 SHALL have port req_we  input  1  1 = store, 0 = load.
REQ-008 SHALL have port req_funct3  input  3  RV32I width/sign code (LB/LH/LW/LBU/LHU, SB/SH/SW).
REQ-009 SHALL have port req_addr  input  32  byte address.
REQ-010 SHALL have port req_wdata  input  32  store data, right-aligned.
REQ-011 SHALL have port rsp_valid  output  1  one-cycle completion pulse.
REQ-012 SHALL have port rsp_rdata  output  32  aligned, extended load result.
REQ-013 SHALL have port rsp_err  output  1  misaligned or illegal funct3.
REQ-014 SHALL have port mem_wr_en  output  1  data-memory write enable.
REQ-015 SHALL have port mem_addr  output  ADDR  data-memory word address.
REQ-016 SHALL have port mem_d_in  output  32  data-memory write data.
REQ-017 SHALL have port mem_d_out  input  32  data-memory read data, valid the cycle after a non-write access.

Function
REQ-018 SHALL implement states IDLE, LOAD_WAIT, RMW_MERGE, DONE; req_ready = 1 only in IDLE with rst_n high.
REQ-019 SHALL accept a request on a clk edge where req_valid & req_ready; word index = req_addr[ADDR+1:2], upper bits ignored.
REQ-020 Accept cycle drives mem_addr combinationally from req_addr; all later cycles drive the latched index.
REQ-021 Load: accept cycle mem_wr_en=0 -> LOAD_WAIT; in LOAD_WAIT rsp_valid=1, rsp_rdata extracted from mem_d_out by addr[1:0], sign-extended (LB/LH) or zero-extended (LBU/LHU) -> IDLE; latency accept+1.
REQ-022 SW: accept cycle mem_wr_en=1, mem_d_in=req_wdata -> DONE; DONE asserts rsp_valid=1, rsp_rdata=0 -> IDLE.
REQ-023 SB/SH: accept cycle mem_wr_en=0 (read) -> RMW_MERGE; RMW_MERGE drives mem_wr_en=1, mem_d_in = mem_d_out with only the addressed byte lanes replaced from latched wdata -> DONE; response at accept+2.
REQ-024 Misaligned (LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0) or illegal funct3 (load 011/110/111, store >=011): no memory write, -> DONE, rsp_valid=1, rsp_err=1, rsp_rdata=0.
REQ-025 rsp_err SHALL be 0 whenever rsp_valid is 0 or the access was legal; rsp_rdata SHALL be 0 when rsp_valid is 0.
REQ-026 mem_wr_en SHALL be asserted only in a SW accept cycle or RMW_MERGE, at most one write per request.
REQ-027 req_valid held or changed while req_ready=0 SHALL have no effect; back-to-back requests accepted in the cycle after rsp_valid.

Reset
REQ-028 rst_n low SHALL immediately force state IDLE, latched request registers 0, and req_ready=0, mem_wr_en=0, rsp_valid=0, rsp_err=0, rsp_rdata=0, mem_addr=0, mem_d_in=0.
REQ-029 Reset asserted during LOAD_WAIT, RMW_MERGE or DONE SHALL abort the request: no write and no rsp_valid after release.

Structure
REQ-030 Package lsu_pkg SHALL hold funct3 localparams (LB..SW) and the state enum.
REQ-031 Byte-lane extract/sign-extend and merge logic SHALL live in one combinational sub-module lsu_align.

Verification
REQ-032 LB addr 0x003, word 0 = 0x80FF_1234 -> rsp at accept+1, rsp_rdata 0xFFFF_FF80, rsp_err 0.
REQ-033 LHU addr 0x006, word 1 = 0xBEEF_0000 -> rsp_rdata 0x0000_BEEF.
REQ-034 SB addr 0x009 wdata 0xAA, word 2 = 0x1122_3344 -> one write of 0x1122_AA44 at accept+1, rsp at accept+2.
REQ-035 SW addr 0x00C wdata 0xDEAD_BEEF -> write at accept cycle, rsp at accept+1; then LW addr 0x00C returns 0xDEAD_BEEF.
REQ-036 SH addr 0x011 -> rsp_err=1 at accept+1, mem_wr_en never asserted, word 4 unchanged.
REQ-037 rst_n low in RMW_MERGE of an SB -> no write, memory word unchanged, no rsp_valid, req_ready=1 one cycle after release.
